// File: rtl/tf_requantization_if.sv
// tf_requantization_if
// Groups the two streaming handshakes of the requantization pipeline:
// the accumulator beat stream coming in and the activation stream going out.
//   accum_valid_i / accum_ready_o / accum_data_i        : input beat stream
//   out_valid_o / out_ready_i / neuron_activation_o     : output activation stream
// Modports:
//   slave  : the requantization block (consumes beats, produces activations)
//   master : the environment (produces beats, consumes activations)
interface tf_requantization_if #(
    parameter int ACCUM_BIT_WIDTH        = 32,
    parameter int NEURON_ACTIV_BIT_WIDTH = 8
);
    logic                              accum_valid_i;
    logic                              accum_ready_o;
    logic [ACCUM_BIT_WIDTH-1:0]        accum_data_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [NEURON_ACTIV_BIT_WIDTH-1:0] neuron_activation_o;

    modport slave (
        input  accum_valid_i,
        input  accum_data_i,
        output accum_ready_o,
        output out_valid_o,
        input  out_ready_i,
        output neuron_activation_o
    );

    modport master (
        output accum_valid_i,
        output accum_data_i,
        input  accum_ready_o,
        input  out_valid_o,
        output out_ready_i,
        input  neuron_activation_o
    );
endinterface

// File: rtl/tf_requantization.sv
// tf_requantization
// Four-stage valid/ready pipeline that turns raw signed convolution
// accumulator results into unsigned activations for the next layer:
//   S1  subtract the active zero-point correction term
//   S2  multiply by the fixed-point requantization multiplier
//   S3  rounding arithmetic right shift (round half toward +inf)
//   S4  add output zero point, optional ReLU floor, clamp to N bits
// Ports:
//   clk, layer_reset_n                : clock, async active-low reset
//   scale_load_i, quan_scale_i        : load a new correction term
//   requan_mult_i, requan_shift_i,
//   out_zero_i, relu_en_i             : per-layer static configuration
//   sat_flag_o                        : sticky saturation indicator
//   bus (slave)                       : accumulator in / activation out streams
module tf_requantization #(
    parameter int ACCUM_BIT_WIDTH        = 32,
    parameter int QUAN_SCALE_BIT_WIDTH   = 24,
    parameter int REQUAN_MULT_BIT_WIDTH  = 16,
    parameter int REQUAN_SHIFT_BIT_WIDTH = 5,
    parameter int NEURON_ACTIV_BIT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              layer_reset_n,
    input  logic                              scale_load_i,
    input  logic [QUAN_SCALE_BIT_WIDTH-1:0]   quan_scale_i,
    input  logic [REQUAN_MULT_BIT_WIDTH-1:0]  requan_mult_i,
    input  logic [REQUAN_SHIFT_BIT_WIDTH-1:0] requan_shift_i,
    input  logic [NEURON_ACTIV_BIT_WIDTH-1:0] out_zero_i,
    input  logic                              relu_en_i,
    output logic                              sat_flag_o,
    tf_requantization_if.slave                bus
);
    localparam int A      = ACCUM_BIT_WIDTH;
    localparam int Q      = QUAN_SCALE_BIT_WIDTH;
    localparam int M      = REQUAN_MULT_BIT_WIDTH;
    localparam int N      = NEURON_ACTIV_BIT_WIDTH;
    localparam int DIFF_W = A + 1;
    localparam int PROD_W = A + M + 2;
    // One extra bit so res + zero point can never wrap.
    localparam int V_W    = PROD_W + 1;

    logic [Q-1:0]               r_scale;
    logic                       r_v1, r_v2, r_v3, r_out_valid;
    logic signed [DIFF_W-1:0]   r_diff;
    logic signed [PROD_W-1:0]   r_prod;
    logic signed [PROD_W-1:0]   r_res;
    logic [N-1:0]               r_act;
    logic                       r_sat;

    logic                       w_advance;
    logic signed [DIFF_W-1:0]   w_diff;
    logic signed [PROD_W-1:0]   w_diff_ext;
    logic signed [PROD_W-1:0]   w_mult_ext;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [PROD_W-1:0]   w_rnd;
    logic signed [PROD_W-1:0]   w_sum;
    logic signed [PROD_W-1:0]   w_res;
    logic signed [V_W-1:0]      w_zero_ext;
    logic signed [V_W-1:0]      w_v;
    logic signed [V_W-1:0]      w_v_relu;
    logic signed [V_W-1:0]      w_max;
    logic                       w_lo;
    logic                       w_hi;
    logic [N-1:0]               w_act;

    // The whole pipeline moves as one: it can advance whenever the output
    // register is empty or being drained this cycle.
    assign w_advance         = ~r_out_valid | bus.out_ready_i;
    assign bus.accum_ready_o = w_advance;

    always_comb begin
        w_diff = $signed({bus.accum_data_i[A-1], bus.accum_data_i})
               - $signed({{(DIFF_W-Q){1'b0}}, r_scale});
    end

    always_comb begin
        w_diff_ext = {{(PROD_W-DIFF_W){r_diff[DIFF_W-1]}}, r_diff};
        w_mult_ext = {{(PROD_W-M){1'b0}}, requan_mult_i};
        w_prod     = w_diff_ext * w_mult_ext;
    end

    always_comb begin
        w_rnd = '0;
        if (requan_shift_i != '0) begin
            w_rnd = {{(PROD_W-1){1'b0}}, 1'b1} << (requan_shift_i - 1'b1);
        end
        w_sum = r_prod + w_rnd;
        w_res = w_sum >>> requan_shift_i;
    end

    always_comb begin
        w_zero_ext = {{(V_W-N){1'b0}}, out_zero_i};
        w_max      = {{(V_W-N){1'b0}}, {N{1'b1}}};
        w_v        = {r_res[PROD_W-1], r_res} + w_zero_ext;
        w_v_relu   = w_v;
        if (relu_en_i && (w_v < w_zero_ext)) begin
            w_v_relu = w_zero_ext;
        end
        w_lo  = w_v_relu < 0;
        w_hi  = w_v_relu > w_max;
        w_act = w_v_relu[N-1:0];
        if (w_lo) begin
            w_act = '0;
        end else if (w_hi) begin
            w_act = '1;
        end
    end

    // A beat accepted alongside scale_load_i still sees the old term because
    // S1 reads r_scale before this edge updates it.
    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            r_scale <= '0;
        end else if (scale_load_i) begin
            r_scale <= quan_scale_i;
        end
    end

    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_prod      <= '0;
            r_res       <= '0;
            r_act       <= '0;
        end else if (w_advance) begin
            r_v1        <= bus.accum_valid_i;
            r_v2        <= r_v1;
            r_v3        <= r_v2;
            r_out_valid <= r_v3;
            r_diff      <= w_diff;
            r_prod      <= w_prod;
            r_res       <= w_res;
            r_act       <= w_act;
        end
    end

    // Sticky flag: a saturating beat landing in S4 wins over a clear.
    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            r_sat <= 1'b0;
        end else if (w_advance && r_v3 && (w_lo || w_hi)) begin
            r_sat <= 1'b1;
        end else if (scale_load_i) begin
            r_sat <= 1'b0;
        end
    end

    assign bus.out_valid_o         = r_out_valid;
    assign bus.neuron_activation_o = r_act;
    assign sat_flag_o              = r_sat;
endmodule
